// File: rtl/enigma_uart_tx_if.sv
// Letter handshake between the enigma core and the UART transmitter.
// A letter transfers on every rising edge where letter_valid and letter_ready are both high;
// letter_in must be stable while letter_valid is high, and letter_ready never depends on letter_valid.
interface enigma_uart_tx_if;
    logic [7:0] letter_in;
    logic       letter_valid;
    logic       letter_ready;

    modport master (
        output letter_in,
        output letter_valid,
        input  letter_ready
    );

    modport slave (
        input  letter_in,
        input  letter_valid,
        output letter_ready
    );
endinterface

// File: rtl/enigma_uart_tx.sv
// Enigma letter-to-ASCII UART transmitter: FIFO-buffered 8N1 serialiser (8E1 when the
// ENIGMA_TX_PARITY_EN macro is defined). Synchronous active-low reset.
module enigma_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        CLOCK_50,
    input  logic                        resetn,
    enigma_uart_tx_if.slave             letter,
    output logic                        tx,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [2:0]                  fsm_state
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef ENIGMA_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shreg, shreg_n;
    logic          tx_n;
    logic          ready, push, pop, baud_wrap, fifo_empty;
    logic [7:0]    push_byte;

    // Ready comes from the registered count only, so a full FIFO rejects even during a pop.
    assign ready      = (count != DEPTH);
    assign push       = letter.letter_valid & ready;
    assign baud_wrap  = (baud == BAUD_LAST);
    assign fifo_empty = (count == '0);
    assign push_byte  = (letter.letter_in < 8'd26) ? (8'h41 + letter.letter_in) : 8'h3F;

    assign letter.letter_ready = ready;
    assign busy                = (state != S_IDLE) || !fifo_empty;
    assign fifo_count          = count;
    assign fsm_state           = state;

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        baud_n  = baud_wrap ? '0 : baud + 1'b1;
        bit_n   = bit_idx;
        shreg_n = shreg;
        tx_n    = 1'b1;

        case (state)
            S_IDLE: begin
                baud_n = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = S_START;
                end
            end
            S_START: begin
                bit_n = '0;
                if (baud_wrap) state_n = S_DATA;
            end
            S_DATA: begin
                if (baud_wrap) begin
                    bit_n = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef ENIGMA_TX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end
                end
            end
`ifdef ENIGMA_TX_PARITY_EN
            S_PARITY: begin
                if (baud_wrap) state_n = S_STOP;
            end
`endif
            S_STOP: begin
                if (baud_wrap) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_n = S_START;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (pop) begin
            shreg_n = mem[rd_ptr];
            baud_n  = '0;
        end

        // tx is registered, so it is derived from the state being entered.
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shreg_n[bit_n];
`ifdef ENIGMA_TX_PARITY_EN
            S_PARITY: tx_n = ^shreg_n;
`endif
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (push) mem[wr_ptr] <= push_byte;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state    <= S_IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
            tx      <= tx_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (letter.letter_valid && !ready) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_enigma_uart_tx.sv
// Testbench for enigma_uart_tx: table vectors, hand-written frame/burst/reset sequences,
// and randomized letters decoded by a line-level UART receiver model.
module tb_enigma_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef ENIGMA_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic       tx, busy, overflow;
    logic [2:0] fifo_count;
    logic [2:0] fsm_state;

    enigma_uart_tx_if lif();

    enigma_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .letter     (lif),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic       rx_en = 1'b1;
    int         rx_cnt = 0;
    logic [7:0] last_rx = 8'h00;
    logic [7:0] exp_q[$];
    int         rx_start_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] code;
        logic [7:0] exp_byte;
    } vec_t;

    function automatic logic [7:0] ref_ascii(input logic [7:0] code);
        int c = int'(code);
        if (c <= 25) return 8'(65 + c);
        return 8'h3F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge; returns at the following negedge with the strobe dropped.
    task automatic drive_cycle(input logic v, input logic [7:0] code, output logic acc);
        logic rdy;
        rdy = lif.letter_ready;
        lif.letter_valid = v;
        lif.letter_in    = code;
        @(negedge clk);
        acc = v & rdy;
        if (acc && rx_en) exp_q.push_back(ref_ascii(code));
        lif.letter_valid = 1'b0;
    endtask

    task automatic do_reset();
        lif.letter_valid = 1'b0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy=1 after %0d cycles, required 0", budget);
        end
        repeat (2) @(negedge clk);
    endtask

    // Pushes one letter from idle and checks the line cycle by cycle against the ideal frame.
    task automatic frame_check(input logic [7:0] code, input logic [7:0] byt);
        logic       acc;
        logic [10:0] bits;
        bits = '1;
        bits[0] = 1'b0;
        for (int b = 0; b < 8; b++) bits[1 + b] = byt[b];
`ifdef ENIGMA_TX_PARITY_EN
        bits[9] = ^byt;
`endif
        bits[FB - 1] = 1'b1;
        drive_cycle(1'b1, code, acc);
        check("frame_accept", 32'(acc), 32'd1);
        check("frame_pre_start_tx", 32'(tx), 32'd1);
        for (int i = 0; i < FB * CPB; i++) begin
            @(negedge clk);
            check($sformatf("frame_bit%0d_tx", i / CPB), 32'(tx), 32'(bits[i / CPB]));
            check("frame_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        check("frame_end_busy", 32'(busy), 32'd0);
        check("frame_end_tx", 32'(tx), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Line-level receiver: samples each bit in its middle cycle.
    initial begin
        logic [7:0] rx_byte;
        rx_byte = '0;
        forever begin
            @(negedge clk);
            if (rx_en && resetn && tx == 1'b0) begin
                rx_start_q.push_back(cyc);
                repeat (CPB / 2) @(negedge clk);
                check("rx_start_bit", 32'(tx), 32'd0);
                for (int b = 0; b < 8; b++) begin
                    repeat (CPB) @(negedge clk);
                    rx_byte[b] = tx;
                end
`ifdef ENIGMA_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                check("rx_parity_bit", 32'(tx), 32'(^rx_byte));
`endif
                repeat (CPB) @(negedge clk);
                check("rx_stop_bit", 32'(tx), 32'd1);
                rx_cnt++;
                last_rx = rx_byte;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected_frame: got 0x%0h, required no frame", rx_byte);
                end else begin
                    check("rx_data", 32'(rx_byte), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #800000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        vec_t vecs[8];
        logic acc;
        int   prev_cnt;

        vecs[0] = '{8'd0,   8'h41};
        vecs[1] = '{8'd25,  8'h5A};
        vecs[2] = '{8'd7,   8'h48};
        vecs[3] = '{8'd26,  8'h3F};
        vecs[4] = '{8'd30,  8'h3F};
        vecs[5] = '{8'd255, 8'h3F};
        vecs[6] = '{8'd12,  8'h4D};
        vecs[7] = '{8'd31,  8'h3F};

        lif.letter_valid = 1'b0;
        lif.letter_in    = 8'h00;
        resetn           = 1'b0;
        @(negedge clk);
        do_reset();
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ready", 32'(lif.letter_ready), 32'd1);
        check("reset_fifo_count", 32'(fifo_count), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);

        frame_check(8'd7, 8'h48);
`ifdef ENIGMA_TX_PARITY_EN
        frame_check(8'd2, 8'h43);
`endif

        foreach (vecs[i]) begin
            prev_cnt = rx_cnt;
            drive_cycle(1'b1, vecs[i].code, acc);
            check("vec_accept", 32'(acc), 32'd1);
            wait_idle(FB * CPB + 20);
            check("vec_frame_count", 32'(rx_cnt - prev_cnt), 32'd1);
            check($sformatf("vec_byte_code%0d", vecs[i].code), 32'(last_rx), 32'(vecs[i].exp_byte));
        end

        // Burst of five plus one rejected strobe.
        rx_start_q.delete();
        for (int k = 0; k < 6; k++) begin
            if (k == 5) begin
                check("burst_ready_full", 32'(lif.letter_ready), 32'd0);
                check("burst_overflow_before", 32'(overflow), 32'd0);
            end
            drive_cycle(1'b1, 8'(k), acc);
            check("burst_accept", 32'(acc), (k < 5) ? 32'd1 : 32'd0);
        end
        check("burst_overflow_after", 32'(overflow), 32'd1);
        check("burst_ready_after", 32'(lif.letter_ready), 32'd0);
        check("burst_fifo_count", 32'(fifo_count), 32'd4);
        wait_idle(6 * FB * CPB + 20);
        check("burst_frames", 32'(rx_start_q.size()), 32'd5);
        for (int k = 1; k < rx_start_q.size(); k++)
            check("burst_gap", 32'(rx_start_q[k] - rx_start_q[k - 1]), 32'(FB * CPB));
        check("burst_queue_drained", 32'(exp_q.size()), 32'd0);
        check("burst_overflow_sticky", 32'(overflow), 32'd1);

        // Reset during bit 3 of 'Z' with two letters queued.
        rx_en = 1'b0;
        drive_cycle(1'b1, 8'd25, acc);
        drive_cycle(1'b1, 8'd1, acc);
        drive_cycle(1'b1, 8'd2, acc);
        check("midrst_count_before", 32'(fifo_count), 32'd2);
        repeat (13) @(negedge clk);
        check("midrst_bit2_tx", 32'(tx), 32'd0);
        repeat (3) @(negedge clk);
        check("midrst_bit3_tx", 32'(tx), 32'd1);
        check("midrst_busy_before", 32'(busy), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_fifo_count", 32'(fifo_count), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(lif.letter_ready), 32'd1);
        check("midrst_overflow", 32'(overflow), 32'd0);
        resetn = 1'b1;
        begin
            int low_seen = 0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (tx !== 1'b1 || busy !== 1'b0) low_seen++;
            end
            check("midrst_line_quiet", 32'(low_seen), 32'd0);
        end

        // Randomized traffic; valid is raised only when the producer sees ready.
        do_reset();
        rx_en = 1'b1;
        prev_cnt = rx_cnt;
        begin
            int pushed = 0;
            for (int it = 0; it < 40; it++) begin
                int blen = $urandom_range(1, 6);
                for (int j = 0; j < blen; j++) begin
                    logic [7:0] code;
                    code = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(26, 255))
                                                       : 8'($urandom_range(0, 25));
                    drive_cycle(lif.letter_ready, code, acc);
                    if (acc) pushed++;
                end
                repeat ($urandom_range(0, 30)) @(negedge clk);
            end
            wait_idle((DEPTH + 2) * FB * CPB + 20);
            check("rand_frames", 32'(rx_cnt - prev_cnt), 32'(pushed));
            check("rand_queue_drained", 32'(exp_q.size()), 32'd0);
            check("rand_overflow", 32'(overflow), 32'd0);
            check("rand_idle_tx", 32'(tx), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
